// File: rtl/fixed_comparator_tree_sched.sv
// Single-stage pairwise max-|x| layer: lane i competes with lane IN_SIZE-1-i, lower lane wins ties.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its operands.
module fixed_comparator_tree_layer #(
    parameter int IN_SIZE  = 8,
    parameter int IN_WIDTH = 16
) (
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]         op,
    output logic [(IN_SIZE+1)/2-1:0][IN_WIDTH-1:0]   win
);
    localparam int HALF = (IN_SIZE + 1) / 2;
    localparam logic [IN_WIDTH-1:0] ONE = IN_WIDTH'(1);

    // Unsigned magnitude, so the most negative value maps to 2^(W-1) without overflow.
    function automatic logic [IN_WIDTH-1:0] mag(input logic [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? (~x + ONE) : x;
    endfunction

    always_comb begin
        for (int i = 0; i < HALF; i++) begin
            if (mag(op[i]) >= mag(op[IN_SIZE-1-i]))
                win[i] = op[i];
            else
                win[i] = op[IN_SIZE-1-i];
        end
    end
endmodule

// Folding max-|x| finder with outlier flag: one comparator layer reused once per pass.
// Latency: result valid $clog2(IN_SIZE) cycles (min 1) after the input handshake.
// Backpressure: result held in DONE until data_out_ready; input accepted only in IDLE.
module fixed_comparator_tree_sched #(
    parameter int IN_SIZE  = 8,
    parameter int IN_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_in,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic [IN_WIDTH-1:0]               threshold,
    output logic [IN_WIDTH-1:0]               data_out,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    output logic                              outlier,
    output logic                              busy
);
    localparam int HALF = (IN_SIZE + 1) / 2;
    localparam int CW   = $clog2(IN_SIZE + 1);
    localparam logic [IN_WIDTH-1:0] ONE = IN_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t                           state, state_nxt;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0] vec_q;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0] op;
    logic [HALF-1:0][IN_WIDTH-1:0]    win;
    logic [CW-1:0]                    cnt_q, cnt_nxt;
    logic [IN_WIDTH-1:0]              thr_q, win_mag;
    logic                             accept, last_pass;

    assign accept    = data_in_valid && data_in_ready;
    assign cnt_nxt   = (cnt_q >> 1) + CW'(cnt_q[0]);
    assign last_pass = (state == REDUCE) && (cnt_nxt == CW'(1));
    assign win_mag   = win[0][IN_WIDTH-1] ? (~win[0] + ONE) : win[0];

    fixed_comparator_tree_layer #(
        .IN_SIZE  (IN_SIZE),
        .IN_WIDTH (IN_WIDTH)
    ) u_layer (
        .op  (op),
        .win (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_in_valid)  state_nxt = REDUCE;
            REDUCE:  if (last_pass)      state_nxt = DONE;
            DONE:    if (data_out_ready) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_in_ready  = (state == IDLE);
        data_out_valid = (state == DONE);
        busy           = (state != IDLE);
    end

    // Fold the live prefix onto itself; an odd middle element meets a zero lane and survives.
    always_comb begin
        op = '0;
        for (int i = 0; i < HALF; i++) begin
            if (2 * i + 1 < int'(cnt_q)) begin
                op[i] = vec_q[i];
                for (int j = 0; j < IN_SIZE; j++)
                    if (i + j + 1 == int'(cnt_q))
                        op[IN_SIZE-1-i] = vec_q[j];
            end else if (2 * i + 1 == int'(cnt_q)) begin
                op[i] = vec_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            cnt_q    <= '0;
            thr_q    <= '0;
            data_out <= '0;
            outlier  <= 1'b0;
        end else if (accept) begin
            vec_q <= data_in;
            cnt_q <= CW'(IN_SIZE);
            thr_q <= threshold;
        end else if (state == REDUCE) begin
            for (int i = 0; i < HALF; i++)
                vec_q[i] <= (i < int'(cnt_nxt)) ? win[i] : '0;
            for (int i = HALF; i < IN_SIZE; i++)
                vec_q[i] <= '0;
            cnt_q <= cnt_nxt;
            if (last_pass) begin
                data_out <= win[0];
                outlier  <= (win_mag >= thr_q);
            end
        end
    end
endmodule

// File: tb/tb_fixed_comparator_tree_sched.sv
// Bench for the folding max-|x| controller: N=8 instance checked every cycle against a
// transaction model, plus N=5/2/1 instances checked against hand-computed results.
module tb_fixed_comparator_tree_sched;
    localparam int W  = 16;
    localparam int P8 = 3;
    typedef logic [7:0][W-1:0] vec8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    vec8_t d8, sd;
    logic [W-1:0] t8, o8, sthr, so5, so2, so1;
    logic v8, rdy8, ov8, or8, outl8, busy8;
    logic sv, sor, srdy5, srdy2, srdy1, sov5, sov2, sov1;
    logic soutl5, soutl2, soutl1, sbusy5, sbusy2, sbusy1;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fixed_comparator_tree_sched #(.IN_SIZE(8), .IN_WIDTH(W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .data_in(d8), .data_in_valid(v8), .data_in_ready(rdy8),
        .threshold(t8), .data_out(o8), .data_out_valid(ov8), .data_out_ready(or8),
        .outlier(outl8), .busy(busy8));
    fixed_comparator_tree_sched #(.IN_SIZE(5), .IN_WIDTH(W)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .data_in(sd[4:0]), .data_in_valid(sv), .data_in_ready(srdy5),
        .threshold(sthr), .data_out(so5), .data_out_valid(sov5), .data_out_ready(sor),
        .outlier(soutl5), .busy(sbusy5));
    fixed_comparator_tree_sched #(.IN_SIZE(2), .IN_WIDTH(W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(sd[1:0]), .data_in_valid(sv), .data_in_ready(srdy2),
        .threshold(sthr), .data_out(so2), .data_out_valid(sov2), .data_out_ready(sor),
        .outlier(soutl2), .busy(sbusy2));
    fixed_comparator_tree_sched #(.IN_SIZE(1), .IN_WIDTH(W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(sd[0:0]), .data_in_valid(sv), .data_in_ready(srdy1),
        .threshold(sthr), .data_out(so1), .data_out_valid(sov1), .data_out_ready(sor),
        .outlier(soutl1), .busy(sbusy1));

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0b required %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %04h required %04h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? W'(-x) : x;
    endfunction

    // Reference: repeatedly fold element i against element n-1-i, lower index keeps ties.
    function automatic logic [W-1:0] fold(input vec8_t v, input int n);
        logic [W-1:0] a [8];
        int c;
        for (int i = 0; i < 8; i++) a[i] = v[i];
        c = n;
        while (c > 1) begin
            for (int i = 0; i < c / 2; i++)
                if (mag(a[c-1-i]) > mag(a[i])) a[i] = a[c-1-i];
            c = (c + 1) / 2;
        end
        return a[0];
    endfunction

    function automatic vec8_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        vec8_t v;
        v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3);
        v[4] = W'(a4); v[5] = W'(a5); v[6] = W'(a6); v[7] = W'(a7);
        return v;
    endfunction

    // Transaction-level model of the N=8 instance, compared on every falling edge.
    initial begin
        int m_mode;
        int m_left;
        logic [W-1:0] m_out;
        logic m_outl;
        m_mode = 0; m_left = 0; m_out = '0; m_outl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) m_mode = 0;
            chk1("model_in_ready", rdy8, m_mode == 0);
            chk1("model_busy", busy8, m_mode != 0);
            chk1("model_out_valid", ov8, m_mode == 2);
            if (m_mode == 2) begin
                chk16("model_data_out", o8, m_out);
                chk1("model_outlier", outl8, m_outl);
            end
            if (rst_n) begin
                case (m_mode)
                    0: if (v8) begin
                        m_out  = fold(d8, 8);
                        m_outl = (mag(m_out) >= t8);
                        m_left = P8;
                        m_mode = 1;
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) m_mode = 2;
                    end
                    default: if (or8) m_mode = 0;
                endcase
            end
        end
    end

    task automatic send8(input vec8_t v, input logic [W-1:0] th, output int acc);
        int n;
        n = 0;
        @(posedge clk); #1;
        d8 = v; t8 = th; v8 = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy8 || n > 40) break;
            n++;
        end
        chk1("send8_in_ready", rdy8, 1'b1);
        @(posedge clk); #1;
        v8 = 1'b0;
        acc = cyc;
    endtask

    task automatic wait8(input int acc, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov8 && n < 40);
        lat = ov8 ? cyc - acc : -1;
    endtask

    task automatic run_small(input vec8_t v, input logic [W-1:0] th,
                             input logic [W-1:0] e5, input logic x5,
                             input logic [W-1:0] e2, input logic x2,
                             input logic [W-1:0] e1, input logic x1);
        int l5, l2, l1, c0;
        l5 = -1; l2 = -1; l1 = -1;
        @(posedge clk); #1;
        sd = v; sthr = th; sv = 1'b1;
        @(negedge clk);
        chk1("small5_in_ready", srdy5, 1'b1);
        chk1("small2_in_ready", srdy2, 1'b1);
        chk1("small1_in_ready", srdy1, 1'b1);
        @(posedge clk); #1;
        sv = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk1("small5_busy", sbusy5, 1'b1);
                chk1("small2_busy", sbusy2, 1'b1);
                chk1("small1_busy", sbusy1, 1'b1);
            end
            if (sov5 && l5 < 0) begin
                l5 = cyc - c0;
                chk16("small5_data_out", so5, e5);
                chk1("small5_outlier", soutl5, x5);
            end
            if (sov2 && l2 < 0) begin
                l2 = cyc - c0;
                chk16("small2_data_out", so2, e2);
                chk1("small2_outlier", soutl2, x2);
            end
            if (sov1 && l1 < 0) begin
                l1 = cyc - c0;
                chk16("small1_data_out", so1, e1);
                chk1("small1_outlier", soutl1, x1);
            end
        end
        chki("small5_latency", l5, 3);
        chki("small2_latency", l2, 1);
        chki("small1_latency", l1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, lat;
        int accs [4];
        vec8_t tv [4];
        logic [W-1:0] tt [4];

        rst_n = 1'b0; v8 = 1'b0; d8 = '0; t8 = '0; or8 = 1'b1;
        sv = 1'b0; sd = '0; sthr = '0; sor = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk16("reset_data_out", o8, 16'h0000);
        chk1("reset_out_valid", ov8, 1'b0);
        chk1("reset_outlier", outl8, 1'b0);
        chk1("reset_busy", busy8, 1'b0);
        chk1("reset_in_ready", rdy8, 1'b1);
        rst_n = 1'b1;

        // Case 1: basic N=8 reduction.
        send8(mk(3, -7, 100, -200, 5, 0, 1, -1), 16'd150, acc);
        wait8(acc, lat);
        chki("t1_latency", lat, 3);
        chk16("t1_data_out", o8, 16'hFF38);
        chk1("t1_outlier", outl8, 1'b1);

        // Case 2 and ties on the narrow instances.
        run_small(mk(1, 2, -9, 3, 4, 0, 0, 0), 16'd10, 16'hFFF7, 1'b0, 16'd2, 1'b0, 16'd1, 1'b0);
        run_small(mk(5, -5, 0, 0, 0, 0, 0, 0), 16'd5, 16'd5, 1'b1, 16'd5, 1'b1, 16'd5, 1'b1);
        run_small(mk(-32768, 32767, 0, 0, 0, 0, 0, 0), 16'h8000,
                  16'h8000, 1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1);

        // Case 3: most-negative magnitude and threshold boundaries.
        send8(mk(32767, -32768, 0, 0, 0, 0, 0, 0), 16'h8000, acc);
        wait8(acc, lat);
        chk16("t3_data_out", o8, 16'h8000);
        chk1("t3_outlier_eq", outl8, 1'b1);
        send8(mk(32767, -32768, 0, 0, 0, 0, 0, 0), 16'h8001, acc);
        wait8(acc, lat);
        chk1("t3_outlier_below", outl8, 1'b0);
        send8(mk(0, 0, 0, 0, 0, 0, 0, 0), 16'h0000, acc);
        wait8(acc, lat);
        chk16("t3_zero_data_out", o8, 16'h0000);
        chk1("t3_zero_outlier", outl8, 1'b1);
        send8(mk(-9, 0, 0, 0, 0, 0, 0, 9), 16'd9, acc);
        wait8(acc, lat);
        chk16("t3_tie_lower_lane", o8, 16'hFFF7);
        send8(mk(0, 0, 0, 9, -9, 0, 0, 0), 16'd10, acc);
        wait8(acc, lat);
        chk16("t3_tie_folded", o8, 16'd9);
        chk1("t3_tie_outlier", outl8, 1'b0);

        // Case 4: output backpressure.
        @(posedge clk); #1;
        or8 = 1'b0;
        send8(mk(1, 2, 3, 4, 5, 6, 7, -8), 16'd8, acc);
        wait8(acc, lat);
        chki("t4_latency", lat, 3);
        @(posedge clk); #1;
        d8 = mk(100, 0, 0, 0, 0, 0, 0, 0); t8 = '0; v8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk1("t4_hold_valid", ov8, 1'b1);
            chk16("t4_hold_data_out", o8, 16'hFFF8);
            chk1("t4_hold_outlier", outl8, 1'b1);
            chk1("t4_hold_in_ready", rdy8, 1'b0);
        end
        @(posedge clk); #1;
        v8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        chk1("t4_release_valid", ov8, 1'b1);
        @(negedge clk);
        chk1("t4_ready_after_release", rdy8, 1'b1);
        chk1("t4_no_second_accept", busy8, 1'b0);

        // Case 5: reset during the second pass.
        send8(mk(3, -7, 100, -200, 5, 0, 1, -1), 16'd150, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk16("t5_reset_data_out", o8, 16'h0000);
        chk1("t5_reset_out_valid", ov8, 1'b0);
        chk1("t5_reset_outlier", outl8, 1'b0);
        chk1("t5_reset_busy", busy8, 1'b0);
        chk1("t5_reset_in_ready", rdy8, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send8(mk(0, 0, 0, 0, 0, 0, 0, 4), 16'd5, acc);
        wait8(acc, lat);
        chki("t5_latency", lat, 3);
        chk16("t5_data_out", o8, 16'd4);
        chk1("t5_outlier", outl8, 1'b0);

        // Case 6: back-to-back with the sink always ready.
        tv[0] = mk(3, -7, 100, -200, 5, 0, 1, -1); tt[0] = 16'd150;
        tv[1] = mk(1, 2, -9, 3, 4, 0, 0, 0);       tt[1] = 16'd10;
        tv[2] = mk(-9, 0, 0, 0, 0, 0, 0, 9);       tt[2] = 16'd2;
        tv[3] = mk(0, 0, 0, 0, 0, 0, 0, 4);        tt[3] = 16'd4;
        for (int k = 0; k < 4; k++) send8(tv[k], tt[k], accs[k]);
        wait8(accs[3], lat);
        chk16("t6_last_data_out", o8, 16'd4);
        chk1("t6_last_outlier", outl8, 1'b1);
        for (int k = 1; k < 4; k++) chki("t6_spacing", accs[k] - accs[k-1], 5);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
